// File: rtl/uart_serial_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling, one-cycle byte strobe.
// Optional macro UART_RX_FRAME_CHECK_EN drops frames whose stop bit samples low.
module uart_serial_rx #(
  parameter int unsigned CLKS_PER_BIT = 87
) (
  input  logic       i_Clock,
  input  logic       reset,
  input  logic       i_Rx_Serial,
  output logic       out_serial,
  output logic [7:0] fullout,
  output logic       uartFlag
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_CLEANUP
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       sh_q, sh_d;
  logic [7:0]       fullout_q, fullout_d;
  logic             flag_q, flag_d;
  logic             seen_high_q, seen_high_d;
  logic             sync1_q, sync2_q;
  logic             line_c;
  logic             stop_ok_c;

  assign line_c = sync2_q;

`ifdef UART_RX_FRAME_CHECK_EN
  assign stop_ok_c = line_c;
`else
  assign stop_ok_c = 1'b1;
`endif

  // State and datapath registers; sync flops reset to idle-high.
  always_ff @(posedge i_Clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      sh_q        <= '0;
      fullout_q   <= '0;
      flag_q      <= 1'b0;
      seen_high_q <= 1'b0;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      sh_q        <= sh_d;
      fullout_q   <= fullout_d;
      flag_q      <= flag_d;
      seen_high_q <= seen_high_d;
      sync1_q     <= i_Rx_Serial;
      sync2_q     <= sync1_q;
    end
  end

  // Next-state logic; seen_high blocks re-triggering on a held-low (break) line.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    sh_d        = sh_q;
    fullout_d   = fullout_q;
    flag_d      = 1'b0;
    seen_high_d = seen_high_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (line_c) begin
          seen_high_d = 1'b1;
        end else if (seen_high_q) begin
          seen_high_d = 1'b0;
          state_d     = S_START;
        end
      end

      S_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          state_d = line_c ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d       = '0;
          sh_d[idx_q] = line_c;
          if (idx_q == 3'd7) begin
            idx_d   = '0;
            state_d = S_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_CLEANUP;
          if (stop_ok_c) begin
            fullout_d = sh_q;
            flag_d    = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_CLEANUP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign out_serial = sync2_q;
  assign fullout    = fullout_q;
  assign uartFlag   = flag_q;

endmodule

// File: tb/tb_uart_serial_rx.sv
// Directed bench for uart_serial_rx at 16 clocks per bit: vector table plus
// hand sequences for back-to-back, glitch, mid-frame reset and break.
module tb_uart_serial_rx;

  localparam int unsigned CPB = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       out_serial;
  logic [7:0] fullout;
  logic       uart_flag;

  uart_serial_rx #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock    (clk),
    .reset      (rst_n),
    .i_Rx_Serial(rx),
    .out_serial (out_serial),
    .fullout    (fullout),
    .uartFlag   (uart_flag)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor: logs bytes, pulse width and any fullout change off-strobe.
  int          n_strobe = 0;
  int          wide_err = 0;
  int          chg_err = 0;
  int unsigned strobe_cyc = 0;
  logic        prev_flag = 1'b0;
  logic [7:0]  prev_out = 8'h00;
  logic [7:0]  got[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_flag <= 1'b0;
      prev_out  <= fullout;
    end else begin
      if (uart_flag === 1'b1) begin
        n_strobe   <= n_strobe + 1;
        strobe_cyc <= cyc;
        got.push_back(fullout);
        if (prev_flag === 1'b1) wide_err <= wide_err + 1;
      end else if (fullout !== prev_out) begin
        chg_err <= chg_err + 1;
      end
      prev_flag <= uart_flag;
      prev_out  <= fullout;
    end
  end

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic send_bit(input logic v);
    rx = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_strobe;
    logic [7:0] exp_out;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int          base;
    int unsigned drive_cyc;
    int unsigned lat;
    logic [31:0] word;

    vecs[0] = '{8'h00, 1'b1, 1'b1, 8'h00};
    vecs[1] = '{8'hFF, 1'b1, 1'b1, 8'hFF};
    vecs[2] = '{8'h80, 1'b1, 1'b1, 8'h80};
    vecs[3] = '{8'h01, 1'b1, 1'b1, 8'h01};
`ifdef UART_RX_FRAME_CHECK_EN
    vecs[4] = '{8'h55, 1'b0, 1'b0, 8'h01};
`else
    vecs[4] = '{8'h55, 1'b0, 1'b1, 8'h55};
`endif
    vecs[5] = '{8'hC3, 1'b1, 1'b1, 8'hC3};
    vecs[6] = '{8'h6A, 1'b1, 1'b1, 8'h6A};

    // Reset values and quiet idle line
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_fullout", 32'(fullout), 32'h00);
    check("reset_flag", 32'(uart_flag), 32'h0);
    check("reset_out_serial", 32'(out_serial), 32'h1);
    rst_n = 1'b1;
    repeat (1000) @(posedge clk);
    #1;
    check("idle_no_strobe", 32'(n_strobe), 32'd0);

    // Single byte with latency measurement
    base      = n_strobe;
    drive_cyc = cyc;
    send_byte(8'h37, 1'b1);
    idle(2 * CPB);
    check("b37_strobes", 32'(n_strobe - base), 32'd1);
    check("b37_fullout_held", 32'(fullout), 32'h37);
    lat = strobe_cyc - drive_cyc - 1;
    check("b37_latency_in_range", 32'((lat >= 152) && (lat <= 154)), 32'd1);

    // Vector table
    for (int v = 0; v < 7; v++) begin
      base = n_strobe;
      send_byte(vecs[v].data, vecs[v].stop);
      idle(4 * CPB);
      check($sformatf("vec%0d_strobes", v), 32'(n_strobe - base), 32'(vecs[v].exp_strobe));
      check($sformatf("vec%0d_fullout", v), 32'(fullout), 32'(vecs[v].exp_out));
    end

    // Back-to-back frames packed MSB-first into a word
    base = n_strobe;
    send_byte(8'hDE, 1'b1);
    send_byte(8'hAD, 1'b1);
    send_byte(8'hBE, 1'b1);
    send_byte(8'hEF, 1'b1);
    idle(4 * CPB);
    check("b2b_strobes", 32'(n_strobe - base), 32'd4);
    word = 32'h0;
    if (got.size() >= base + 4)
      for (int i = 0; i < 4; i++) word = {word[23:0], got[base + i]};
    check("b2b_word", word, 32'hDEADBEEF);

    // Short low glitch, then a real frame
    base = n_strobe;
    rx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    idle(3 * CPB);
    check("glitch_no_strobe", 32'(n_strobe - base), 32'd0);
    send_byte(8'hA5, 1'b1);
    idle(4 * CPB);
    check("after_glitch_strobes", 32'(n_strobe - base), 32'd1);
    check("after_glitch_fullout", 32'(fullout), 32'hA5);

    // Reset during data bit 4 of 0xFF
    base = n_strobe;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rx = 1'b1;
    repeat (CPB / 2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("midreset_fullout", 32'(fullout), 32'h00);
    check("midreset_flag", 32'(uart_flag), 32'h0);
    check("midreset_out_serial", 32'(out_serial), 32'h1);
    rst_n = 1'b1;
    idle(6 * CPB);
    check("aborted_no_strobe", 32'(n_strobe - base), 32'd0);
    send_byte(8'h0F, 1'b1);
    idle(4 * CPB);
    check("after_reset_strobes", 32'(n_strobe - base), 32'd1);
    check("after_reset_fullout", 32'(fullout), 32'h0F);

    // Break: stop bit low and line held low for several bit times
    base = n_strobe;
    send_byte(8'h3C, 1'b0);
    repeat (5 * CPB) @(posedge clk);
    #1;
    idle(4 * CPB);
`ifdef UART_RX_FRAME_CHECK_EN
    check("break_strobes", 32'(n_strobe - base), 32'd0);
    check("break_fullout", 32'(fullout), 32'h0F);
`else
    check("break_strobes", 32'(n_strobe - base), 32'd1);
    check("break_fullout", 32'(fullout), 32'h3C);
`endif
    base = n_strobe;
    send_byte(8'h12, 1'b1);
    idle(4 * CPB);
    check("after_break_strobes", 32'(n_strobe - base), 32'd1);
    check("after_break_fullout", 32'(fullout), 32'h12);

    check("flag_pulse_width", 32'(wide_err), 32'd0);
    check("fullout_stable_off_strobe", 32'(chg_err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
